// File: rtl/mem_1rw_ctrl.sv
// Request-side controller for the single-port mem_1rw macro: arbitrates read and write
// streams round-robin onto the RW port and returns read data through an in-order response FIFO.
module mem_1rw_ctrl #(
    parameter int DEPTH     = 48,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 64,
    parameter int RSP_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(RSP_DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1'b1);
        end
        return nxt;
    endfunction

    logic                 inflight_r;
    logic                 oor_r;
    logic                 rr_last_wr_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 rsp_valid_r;
    logic [RSP_DEPTH-1:0] fifo_err_r;
    logic [DATA_W-1:0]    fifo_data_r [RSP_DEPTH];

    logic [CNT_W:0]       credit_s;
    logic                 rd_ok_s;
    logic                 rd_elig_s;
    logic                 contended_s;
    logic                 wr_gnt_s;
    logic                 rd_gnt_s;
    logic                 wr_in_range_s;
    logic                 rd_in_range_s;
    logic                 push_s;
    logic                 pop_s;
    logic [DATA_W-1:0]    push_data_s;
    logic [CNT_W-1:0]     count_nxt_s;

    // Queued responses plus the one in flight must fit in the FIFO; a same-cycle pop earns no credit.
    assign credit_s      = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    assign rd_ok_s       = (credit_s < (CNT_W + 1)'(RSP_DEPTH));
    assign rd_elig_s     = rd_valid && rd_ok_s;
    assign contended_s   = wr_valid && rd_elig_s;
    assign wr_in_range_s = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign rd_in_range_s = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));

    // Round-robin grant between the write stream and the credit-qualified read stream.
    always_comb begin
        wr_gnt_s = 1'b0;
        rd_gnt_s = 1'b0;
        if (contended_s) begin
            if (rr_last_wr_r) begin
                rd_gnt_s = 1'b1;
            end else begin
                wr_gnt_s = 1'b1;
            end
        end else if (wr_valid) begin
            wr_gnt_s = 1'b1;
        end else if (rd_elig_s) begin
            rd_gnt_s = 1'b1;
        end else begin
            wr_gnt_s = 1'b0;
            rd_gnt_s = 1'b0;
        end
    end

    assign wr_ready = wr_gnt_s;
    assign rd_ready = rd_gnt_s;

    // Drive the macro port; out-of-range requests are accepted but never reach the macro.
    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = {ADDR_W{1'b0}};
        RW0_wdata = {DATA_W{1'b0}};
        if (wr_gnt_s && wr_in_range_s) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = wr_addr;
            RW0_wdata = wr_data;
        end else if (rd_gnt_s && rd_in_range_s) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b0;
            RW0_addr  = rd_addr;
        end else begin
            RW0_en    = 1'b0;
        end
    end

    assign push_s      = inflight_r;
    assign pop_s       = rsp_valid_r && rsp_ready;
    assign push_data_s = oor_r ? {DATA_W{1'b0}} : RW0_rdata;

    // Next FIFO occupancy from push/pop of this cycle.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1'b1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Control state: in-flight read tracking, arbitration history and FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r   <= 1'b0;
            oor_r        <= 1'b0;
            rr_last_wr_r <= 1'b1;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            rsp_valid_r  <= 1'b0;
            fifo_err_r   <= {RSP_DEPTH{1'b0}};
        end else begin
            inflight_r <= rd_gnt_s;
            if (rd_gnt_s) begin
                oor_r <= !rd_in_range_s;
            end
            if (contended_s) begin
                rr_last_wr_r <= wr_gnt_s;
            end
            if (push_s) begin
                fifo_err_r[wr_ptr_r] <= oor_r;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r     <= count_nxt_s;
            rsp_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

    // Response data storage; only entries marked valid by the control state are ever observed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= push_data_s;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = fifo_data_r[rd_ptr_r];
    assign rsp_err   = fifo_err_r[rd_ptr_r];

endmodule

// File: tb/tb_mem_1rw_ctrl.sv
// Self-checking bench for mem_1rw_ctrl: a behavioural macro stub, a credit/round-robin
// reference model with a response scoreboard, directed scenarios and a randomized phase.
module tb_mem_1rw_ctrl;
    localparam int DEPTH     = 48;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 64;
    localparam int RSP_DEPTH = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_valid, wr_ready, rd_valid, rd_ready;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en, RW0_wmode;
    logic [DATA_W-1:0] RW0_wdata, RW0_rdata;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   n_rsp  = 0;
    rsp_t exp_q[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] stub_mem [64];
    int   outstanding = 0;
    bit   last_wr = 1'b1;
    bit   m_rd_el, m_ew, m_er, m_en;

    always #5 clk = ~clk;

    mem_1rw_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    // Macro stub: single RW port, one-cycle read latency, no reset of contents.
    always @(posedge clk) begin
        if (RW0_en) begin
            if (RW0_wmode) stub_mem[RW0_addr] <= RW0_wdata;
            else           RW0_rdata <= stub_mem[RW0_addr];
        end
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: credit = accepted reads not yet popped; grants and port activity checked each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            last_wr     = 1'b1;
        end else begin
            m_rd_el = rd_valid && (outstanding < RSP_DEPTH);
            if (wr_valid && m_rd_el) begin
                m_er = last_wr;
                m_ew = !last_wr;
            end else begin
                m_ew = wr_valid;
                m_er = m_rd_el;
            end
            check("wr_ready", wr_ready, m_ew);
            check("rd_ready", rd_ready, m_er);
            m_en = (m_ew && wr_addr < DEPTH) || (m_er && rd_addr < DEPTH);
            check("RW0_en", RW0_en, m_en);
            if (m_en) begin
                check("RW0_wmode", RW0_wmode, m_ew);
                check("RW0_addr", RW0_addr, m_ew ? wr_addr : rd_addr);
                if (m_ew) check("RW0_wdata", RW0_wdata, wr_data);
            end else if (!m_ew && !m_er) begin
                check("idle_port", {RW0_wmode, RW0_addr, RW0_wdata}, '0);
            end
            if (wr_valid && wr_ready && wr_addr < DEPTH) ref_mem[wr_addr] = wr_data;
            if (rd_valid && rd_ready) begin
                if (rd_addr < DEPTH) exp_q.push_back('{data: ref_mem[rd_addr], err: 1'b0});
                else                 exp_q.push_back('{data: '0, err: 1'b1});
                outstanding++;
            end
            if (wr_valid && rd_valid && m_rd_el) last_wr = wr_ready;
            if (rsp_valid && rsp_ready) outstanding--;
        end
    end

    // Scoreboard monitor: every consumed response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data %h err %0b expected no response", rsp_data, rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", rsp_err, e.err);
                n_rsp++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        tick();
    endtask

    initial begin
        int acc, base, n;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_ready", {wr_ready, rd_ready}, 2'b00);
        check("reset_RW0_en", RW0_en, 1'b0);
        rst_n = 1'b1;
        tick();

        // Fill every word so later reads have a defined reference.
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = {$urandom, $urandom};
            tick();
        end
        idle();

        // Write then read back with latency measured from the handshake cycle.
        wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 64'hDEADBEEF_00000001;
        tick();
        idle();
        rd_valid = 1'b1; rd_addr = 6'd5; rsp_ready = 1'b1;
        @(negedge clk);
        check("lat_handshake", rd_ready, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("lat_cycle1_rsp_valid", rsp_valid, 1'b0);
        tick();
        @(negedge clk);
        check("lat_cycle2_rsp_valid", rsp_valid, 1'b1);
        check("lat_rsp_data", rsp_data, 64'hDEADBEEF_00000001);
        check("lat_rsp_err", rsp_err, 1'b0);
        tick();
        drain();

        // Back-to-back reads at full throughput.
        base = n_rsp;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_valid = 1'b1; rd_addr = ADDR_W'(i);
            @(negedge clk);
            check("stream_rd_ready", rd_ready, 1'b1);
            tick();
        end
        drain();
        check("stream_rsp_count", 64'(n_rsp - base), 64'd10);

        // Backpressure: only RSP_DEPTH reads may be outstanding.
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            rd_valid = 1'b1; rd_addr = ADDR_W'(10 + acc);
            @(negedge clk);
            if (rd_ready) acc++;
            if (c >= 3) check("stall_RW0_en", RW0_en, 1'b0);
            tick();
        end
        check("stall_accepted", 64'(acc), 64'd3);
        rsp_ready = 1'b1;
        n = 0;
        while (acc < 5 && n < 20) begin
            rd_addr = ADDR_W'(10 + acc);
            @(negedge clk);
            if (rd_ready) acc++;
            tick();
            n++;
        end
        check("stall_resumed", 64'(acc), 64'd5);
        drain();

        // Contention right after reset alternates starting with read.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); wr_data = {$urandom, $urandom};
            rd_valid = 1'b1; rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            check("rr_rd_ready", rd_ready, (i % 2) == 0);
            check("rr_wr_ready", wr_ready, (i % 2) == 1);
            check("rr_wmode", RW0_wmode, (i % 2) == 1);
            tick();
        end
        drain();

        // Out-of-range accesses.
        wr_valid = 1'b1; wr_addr = 6'd50; wr_data = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        check("oor_wr_ready", wr_ready, 1'b1);
        check("oor_wr_RW0_en", RW0_en, 1'b0);
        tick();
        wr_addr = 6'd47; wr_data = 64'h0F0F_0F0F_A5A5_5A5A;
        tick();
        idle();
        rd_valid = 1'b1; rd_addr = 6'd50;
        tick();
        rd_addr = 6'd47;
        tick();
        drain();

        // Reset while one read is in flight and two responses are queued.
        rsp_ready = 1'b0;
        acc = 0;
        n = 0;
        while (acc < 3 && n < 10) begin
            rd_valid = 1'b1; rd_addr = ADDR_W'(20 + acc);
            @(negedge clk);
            if (rd_ready) acc++;
            tick();
            n++;
        end
        idle();
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        wr_valid = 1'b1; wr_addr = 6'd30; wr_data = {$urandom, $urandom};
        rd_valid = 1'b1; rd_addr = 6'd31;
        @(negedge clk);
        check("midrst_first_gnt_rd", rd_ready, 1'b1);
        tick();
        drain();

        // Randomized traffic including out-of-range addresses and consumer stalls.
        for (int i = 0; i < 500; i++) begin
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = ADDR_W'($urandom_range(0, 55));
            wr_data   = {$urandom, $urandom};
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addr   = ADDR_W'($urandom_range(0, 55));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
